lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
Multi-cycle load/store sequencer between the decoder/ALU and a variable-latency data-memory port. It takes the decoded mem_read/mem_write, funct3, ALU-computed address and rs2 data. It then runs a req/ack transaction, and stalls the PC and register write-back until the access completes. It also forms byte enables and lane-aligned write data, sign- or zero-extends load data, and reports misaligned, illegal and timeout faults.

Parameters:
TIMEOUT_CYCLES, 255, maximum number of BUSY cycles with dmem_req high before a timeout fault; legal range >= 1.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
mem_read  input  1  decoded load
mem_write  input  1  decoded store
funct3  input  3  access size/sign
addr  input  32  effective address (ALU result)
store_data  input  32  rs2 value
dmem_req  output  1  memory request, registered
dmem_we  output  1  1 = write, registered
dmem_addr  output  32  word address {addr[31:2],2'b00}, registered
dmem_be  output  4  byte enables, registered
dmem_wdata  output  32  lane-replicated write data, registered
dmem_ack  input  1  memory completion; rdata valid with ack
dmem_rdata  input  32  read word
stall  output  1  hold PC/instruction; combinational
done  output  1  one-cycle completion pulse, registered
load_data  output  32  extended load result, registered
fault  output  1  access faulted, valid with done
fault_cause  output  2  01 misaligned, 10 illegal, 11 timeout, 00 none

Behaviour:
- Reset: state=IDLE, counter=0. All registered outputs are 0, including load_data and fault_cause. Reset in any state aborts the access and drops dmem_req at the reset edge.
- access = mem_read|mem_write. stall = (IDLE & access) | BUSY. stall is 0 in DONE.
- Legal loads by funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
- Illegal: any other funct3, or mem_read&mem_write both high.
- Misaligned: halfword access with addr[0]=1; word access with addr[1:0]!=0.
- IDLE, access, illegal: go to DONE with fault=1, cause=10. No bus cycle.
- IDLE, access, misaligned (and legal): go to DONE with fault=1, cause=01. No bus cycle.
- IDLE, access, legal and aligned: latch dmem_addr, dmem_be, dmem_wdata, dmem_we=mem_write, plus funct3 and addr[1:0] for the load path. Set dmem_req=1, counter=0, go to BUSY.
- Byte enables: SB/LB/LBU 4'b0001<<addr[1:0]; SH/LH/LHU 4'b0011<<{addr[1],1'b0}; word 4'b1111.
- Write data: SB {4{store_data[7:0]}}; SH {2{store_data[15:0]}}; SW store_data.
- BUSY: dmem_req and all dmem_* outputs held stable until ack.
  - dmem_ack=1: dmem_req<=0, go to DONE, fault=0, cause=00.
  - On a load ack, load_data <= selected lane of dmem_rdata, sign-extended (LB/LH) or zero-extended (LBU/LHU), or the full word (LW).
  - On a store ack, load_data is unchanged.
  - No ack and counter==TIMEOUT_CYCLES-1: dmem_req<=0, go to DONE, fault=1, cause=11.
  - Otherwise counter increments.
  - Ack and timeout in the same cycle: ack wins.
- DONE: done=1 for exactly one cycle, then unconditionally back to IDLE. The CPU advances the PC and commits RegWrite in this cycle.
  - fault and fault_cause are valid only while done=1 and cleared on leaving DONE.
  - load_data holds its value until the next successful load.
- dmem_ack outside BUSY is ignored.
- Latency with a zero-wait memory (ack in the first BUSY cycle): access seen at cycle 0, BUSY at cycle 1, DONE at cycle 2. stall is high in cycles 0 and 1.
- A fault without a bus cycle completes in 2 cycles (IDLE, then DONE).

Test Plan:
- LW addr=0x100, memory acks after 3 cycles with rdata=0xDEADBEEF -> dmem_addr=0x100, be=1111, we=0; req high 3 cycles; stall high 4 cycles; done pulse; load_data=0xDEADBEEF, fault=0.
- LB addr=0x203, rdata=0x80FFFFFF -> be=1000, load_data=0xFFFFFF80. Same with LBU -> 0x00000080. LH addr=0x202, rdata=0x8001_0000 -> load_data=0xFFFF8001.
- SH addr=0x0A, store_data=0x1234ABCD, zero-wait ack -> dmem_addr=0x08, be=1100, wdata=0xABCDABCD, we=1; done at cycle 2; load_data unchanged.
- LW addr=0x102 -> no dmem_req; done next cycle with fault=1, cause=01. Load funct3=011 -> fault, cause=10. mem_read&mem_write both high -> fault, cause=10.
- TIMEOUT_CYCLES=4, no ack -> req high exactly 4 cycles, then done with cause=11. Ack on the 4th cycle -> success, cause=00.
- rst asserted in the 2nd BUSY cycle -> dmem_req=0, stall=0, done=0 next cycle. A later ack is ignored. A new access after rst deassert completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: runs a req/ack data-memory transaction, stalls the core
// until it completes, and reports misaligned, illegal and timeout faults.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              req_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              done_q;
    logic [31:0]       load_q;
    logic              fault_q;
    logic [1:0]        cause_q;

    logic              access;
    logic              legalF3;
    logic              illegal;
    logic              misaligned;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [7:0]        byteSel;
    logic [15:0]       halfSel;
    logic [31:0]       loadExt_d;

    // Decode of the incoming request: legality, alignment and lane placement.
    always_comb begin
        access     = mem_read | mem_write;
        legalF3    = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = store_data;
        if (mem_read) begin
            legalF3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
        end else begin
            legalF3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end
        illegal    = (mem_read & mem_write) | ~legalF3;
        misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                     ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << addr[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_d    = 4'b0011 << {addr[1], 1'b0};
                wdata_d = {2{store_data[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = store_data;
            end
        endcase
    end

    // Lane selection and extension of the returned read word.
    always_comb begin
        byteSel   = 8'h00;
        case (off_q)
            2'd0:    byteSel = dmem_rdata[7:0];
            2'd1:    byteSel = dmem_rdata[15:8];
            2'd2:    byteSel = dmem_rdata[23:16];
            default: byteSel = dmem_rdata[31:24];
        endcase
        halfSel   = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  loadExt_d = {{24{byteSel[7]}}, byteSel};
            3'b001:  loadExt_d = {{16{halfSel[15]}}, halfSel};
            3'b100:  loadExt_d = {24'h000000, byteSel};
            3'b101:  loadExt_d = {16'h0000, halfSel};
            default: loadExt_d = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            load_q  <= '0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        if (illegal) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                            cause_q <= 2'b10;
                        end else if (misaligned) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                            cause_q <= 2'b01;
                        end else begin
                            addr_q  <= {addr[31:2], 2'b00};
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            we_q    <= mem_write;
                            f3_q    <= funct3;
                            off_q   <= addr[1:0];
                            req_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= BUSY;
                        end
                    end
                end
                // An ack in the final counted cycle still completes successfully.
                BUSY: begin
                    if (dmem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        fault_q <= 1'b0;
                        cause_q <= 2'b00;
                        if (!we_q) begin
                            load_q <= loadExt_d;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        req_q   <= 1'b0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                        cause_q <= 2'b11;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    cause_q <= 2'b00;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall       = ((state_q == IDLE) && access) || (state_q == BUSY);
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_be     = be_q;
    assign dmem_wdata  = wdata_q;
    assign done        = done_q;
    assign load_data   = load_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule
